// File: rtl/vp_sequencer_if.sv
// Sequencer bus: run control, instruction-memory port and datapath control strobes.
interface vp_sequencer_if #(
  parameter int INSTR_W = 60,
  parameter int PC_W    = 8
);
  logic               start;
  logic [PC_W:0]      prog_len;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_addr;
  logic [2:0]         op_code;
  logic               we_a;
  logic               we_b;
  logic               we_mem;
  logic               sel0;
  logic               sel1;
  logic               sel2;
  logic               busy;
  logic               done;
  logic               illegal;

  modport master (
    input  start, prog_len, instr,
    output pc_addr, op_code, we_a, we_b, we_mem, sel0, sel1, sel2, busy, done, illegal
  );

  modport slave (
    output start, prog_len, instr,
    input  pc_addr, op_code, we_a, we_b, we_mem, sel0, sel1, sel2, busy, done, illegal
  );
endinterface

// File: rtl/vp_sequencer.sv
// Fetch/decode/control sequencer for the vector datapath: owns the PC, latches the
// opcode and drives registered write strobes and mux selects.
module vp_sequencer #(
  parameter int INSTR_W = 60,
  parameter int PC_W    = 8,
  parameter int OP_LSB  = 12
) (
  input  logic           clk,
  input  logic           reset,
  vp_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_DONE   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic legal;
    logic sel0;
    logic sel1;
    logic sel2;
    logic we_a;
    logic we_mem;
  } dec_t;

  localparam logic [PC_W:0] MAX_LEN = {1'b1, {PC_W{1'b0}}};
  localparam logic [2:0]    OP_LDR  = 3'b100;

  // Decode table; 010 and 011 come back with legal cleared.
  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d = 6'b000000;
    case (op)
      3'b000, 3'b001, 3'b110: begin
        d.legal = 1'b1;
        d.sel2  = 1'b1;
        d.we_a  = 1'b1;
      end
      3'b100: begin
        d.legal = 1'b1;
        d.sel1  = 1'b1;
      end
      3'b101: begin
        d.legal  = 1'b1;
        d.sel0   = 1'b1;
        d.sel1   = 1'b1;
        d.we_mem = 1'b1;
      end
      3'b111: begin
        d.legal = 1'b1;
        d.we_a  = 1'b1;
      end
      default: d = 6'b000000;
    endcase
    return d;
  endfunction

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W:0]   len_r;
  logic [2:0]      op_r;
  logic            we_a_r;
  logic            we_b_r;
  logic            we_mem_r;
  logic            sel0_r;
  logic            sel1_r;
  logic            sel2_r;
  logic            busy_r;
  logic            done_r;
  logic            illegal_r;

  logic [2:0]      instr_op_s;
  dec_t            dec_s;
  logic [PC_W:0]   pc_inc_s;
  logic            last_s;
  logic [PC_W:0]   start_len_s;
  logic            start_empty_s;

  assign instr_op_s    = bus.instr[OP_LSB+2:OP_LSB];
  assign dec_s         = decode_op(instr_op_s);
  // Compare one bit wider than the PC so a 2**PC_W program retires without wrapping.
  assign pc_inc_s      = {1'b0, pc_r} + {{PC_W{1'b0}}, 1'b1};
  assign last_s        = (pc_inc_s == len_r);
  assign start_len_s   = (bus.prog_len > MAX_LEN) ? MAX_LEN : bus.prog_len;
  assign start_empty_s = (start_len_s == {(PC_W+1){1'b0}});

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      pc_r      <= {PC_W{1'b0}};
      len_r     <= {(PC_W+1){1'b0}};
      op_r      <= 3'b000;
      we_a_r    <= 1'b0;
      we_b_r    <= 1'b0;
      we_mem_r  <= 1'b0;
      sel0_r    <= 1'b0;
      sel1_r    <= 1'b0;
      sel2_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            len_r     <= start_len_s;
            pc_r      <= {PC_W{1'b0}};
            illegal_r <= 1'b0;
            if (start_empty_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_FETCH;
              busy_r  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          state_r <= S_DECODE;
        end
        S_DECODE: begin
          op_r <= instr_op_s;
          if (!dec_s.legal) begin
            illegal_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= S_HALT;
          end else begin
            sel0_r   <= dec_s.sel0;
            sel1_r   <= dec_s.sel1;
            sel2_r   <= dec_s.sel2;
            we_a_r   <= dec_s.we_a;
            we_mem_r <= dec_s.we_mem;
            state_r  <= S_EXEC;
          end
        end
        S_EXEC: begin
          we_a_r   <= 1'b0;
          we_mem_r <= 1'b0;
          if (op_r == OP_LDR) begin
            // LDR keeps its selects and PC for the memory cycle.
            we_b_r  <= 1'b1;
            state_r <= S_MEM;
          end else begin
            sel0_r <= 1'b0;
            sel1_r <= 1'b0;
            sel2_r <= 1'b0;
            if (last_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              pc_r    <= pc_inc_s[PC_W-1:0];
              state_r <= S_FETCH;
            end
          end
        end
        S_MEM: begin
          we_b_r <= 1'b0;
          sel0_r <= 1'b0;
          sel1_r <= 1'b0;
          sel2_r <= 1'b0;
          if (last_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            pc_r    <= pc_inc_s[PC_W-1:0];
            state_r <= S_FETCH;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          we_a_r   <= 1'b0;
          we_b_r   <= 1'b0;
          we_mem_r <= 1'b0;
          sel0_r   <= 1'b0;
          sel1_r   <= 1'b0;
          sel2_r   <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_addr = pc_r;
  assign bus.op_code = op_r;
  assign bus.we_a    = we_a_r;
  assign bus.we_b    = we_b_r;
  assign bus.we_mem  = we_mem_r;
  assign bus.sel0    = sel0_r;
  assign bus.sel1    = sel1_r;
  assign bus.sel2    = sel2_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.illegal = illegal_r;

endmodule
